// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-rate helper
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/tx_baud_generator.sv
// tx_baud_generator: 1x bit-rate divider with a synchronous clear at the handshake
module tx_baud_generator #(
  parameter int CYCLES = 16
) (
  input  logic tx_clk,
  input  logic rst,
  input  logic baud_clr,
  input  logic baud_en,
  output logic bit_tick
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  assign bit_tick = baud_en && cnt == W'(CYCLES - 1);
  always_ff @(posedge tx_clk or posedge rst)
    if (rst) cnt <= '0;
    else if (baud_clr || bit_tick || !baud_en) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one character per handshake as start, data LSB first, optional parity, stop bits
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int TX_SYS_CLK = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 tx_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int TX_CYCLE = cycles_per_bit(TX_SYS_CLK, BAUD_RATE);
  if (TX_CYCLE < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_transmitter: illegal configuration");
  end
  tx_state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic par, par_n, serial_n, done_n, bit_tick, hs;
  assign tx_ready = !rst && state == IDLE;
  assign tx_busy  = state != IDLE;
  assign hs       = tx_valid && tx_ready;
  tx_baud_generator #(.CYCLES(TX_CYCLE)) u_baud (
    .tx_clk  (tx_clk),
    .rst     (rst),
    .baud_clr(hs),
    .baud_en (tx_busy),
    .bit_tick(bit_tick)
  );
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    done_n    = 1'b0;
    case (state)
      IDLE: if (hs) begin
        state_n   = START;
        shift_n   = tx_data;
        bit_cnt_n = '0;
        par_n     = PARITY_ODD != 0 ? ~^tx_data : ^tx_data;
      end
      START: if (bit_tick) state_n = DATA;
      DATA: if (bit_tick) begin
        shift_n   = shift >> 1;
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'(DATA_BITS - 1)) begin
          state_n   = PARITY_EN != 0 ? PARITY : STOP;
          bit_cnt_n = '0;
        end
      end
      PARITY: if (bit_tick) state_n = STOP;
      STOP: if (bit_tick) begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'(STOP_BITS - 1)) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
          done_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // line level follows the state being entered so the registered output lines up with it
    serial_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge tx_clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      par       <= par_n;
      tx_serial <= serial_n;
      tx_done   <= done_n;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: checks 8N1, 8E1, 8O1 and 8N2 transmitters against a frame-level line model
module tb_uart_transmitter;
  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       b9;
    int         len;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] v = '0;
  logic [3:0] ser, rdy, bsy, dn;
  logic [7:0] d [4];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_transmitter #(
      .TX_SYS_CLK(160_000),
      .BAUD_RATE (10_000),
      .DATA_BITS (8),
      .PARITY_EN (g == 1 || g == 2 ? 1 : 0),
      .PARITY_ODD(g == 2 ? 1 : 0),
      .STOP_BITS (g == 3 ? 2 : 1)
    ) dut (
      .tx_clk   (clk),
      .rst      (rst),
      .tx_data  (d[g]),
      .tx_valid (v[g]),
      .tx_ready (rdy[g]),
      .tx_serial(ser[g]),
      .tx_busy  (bsy[g]),
      .tx_done  (dn[g])
    );
  end
  function automatic int pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction
  function automatic int nbits(input int i);
    return 1 + 8 + pe(i) + (i == 3 ? 2 : 1);
  endfunction
  // line level of bit slot n of a frame carrying b on instance i
  function automatic logic exp_bit(input int i, input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (n == 9 && pe(i) == 1) return (^b) ^ (i == 2);
    return 1'b1;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic frame(input int i, input logic [7:0] b, input bit hold, input bit noise,
                       output logic [7:0] dec, output logic b9, output int dat);
    int f, bad, n;
    f = 16 * nbits(i);
    bad = 0;
    dat = -1;
    dec = '0;
    b9 = 1'b0;
    check("ready_before", int'(rdy[i]), 1);
    v[i] = 1'b1;
    d[i] = b;
    @(posedge clk);
    for (int k = 1; k <= f + 1; k++) begin
      @(negedge clk);
      if (!hold) v[i] = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) d[i] = 8'($urandom);
      if (dn[i] && dat < 0) dat = k - 1;
      if (k <= f) begin
        if (ser[i] !== exp_bit(i, b, (k - 1) / 16) || bsy[i] !== 1'b1 || rdy[i] !== 1'b0 || dn[i] !== 1'b0) bad++;
        if ((k - 1) % 16 == 8) begin
          n = (k - 1) / 16;
          if (n >= 1 && n <= 8) dec[n-1] = ser[i];
          if (n == 9) b9 = ser[i];
        end
      end
    end
    if (!hold) v[i] = 1'b0;
    check("line", bad, 0);
    check("end_state", int'({ser[i], bsy[i], rdy[i], dn[i]}), 4'b1011);
  endtask
  initial begin
    vec_t tbl [10];
    logic [7:0] dec, b;
    logic b9;
    int dat, i;
    bit nz;
    tbl = '{
      '{0, 8'h55, 1'b1, 160}, '{1, 8'hA3, 1'b0, 176}, '{2, 8'hA3, 1'b1, 176},
      '{3, 8'hFF, 1'b1, 176}, '{0, 8'h00, 1'b1, 160}, '{1, 8'hFF, 1'b0, 176},
      '{2, 8'hFF, 1'b1, 176}, '{1, 8'h01, 1'b1, 176}, '{2, 8'h01, 1'b0, 176},
      '{3, 8'h5A, 1'b1, 176}
    };
    for (int k = 0; k < 4; k++) d[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_serial", int'(ser), 4'hF);
    check("rst_busy", int'(bsy), 0);
    check("rst_ready", int'(rdy), 0);
    check("rst_done", int'(dn), 0);
    rst = 1'b0;
    #1 check("ready_release", int'(rdy), 4'hF);
    @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      frame(tbl[t].dut, tbl[t].data, 1'b0, 1'b0, dec, b9, dat);
      check("tbl_decode", int'(dec), int'(tbl[t].data));
      check("tbl_bit9", int'(b9), int'(tbl[t].b9));
      check("tbl_done_at", dat, tbl[t].len);
      @(negedge clk);
      check("done_width", int'(dn[tbl[t].dut]), 0);
    end
    frame(0, 8'h00, 1'b1, 1'b0, dec, b9, dat);
    check("b2b_first", int'(dec), 8'h00);
    frame(0, 8'hFF, 1'b0, 1'b0, dec, b9, dat);
    check("b2b_second", int'(dec), 8'hFF);
    check("b2b_done_at", dat, 160);
    @(negedge clk);
    frame(0, 8'h3C, 1'b0, 1'b1, dec, b9, dat);
    check("busy_decode", int'(dec), 8'h3C);
    check("busy_done_at", dat, 160);
    @(negedge clk);
    check("busy_no_second", int'(bsy[0]), 0);
    v[0] = 1'b1;
    d[0] = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    v[0] = 1'b0;
    repeat (71) @(negedge clk);
    check("midframe_busy", int'(bsy[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_serial", int'(ser[0]), 1);
    check("abort_busy", int'(bsy[0]), 0);
    check("abort_ready", int'(rdy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_release", int'(rdy[0]), 1);
    @(negedge clk);
    frame(0, 8'h81, 1'b0, 1'b0, dec, b9, dat);
    check("after_rst_decode", int'(dec), 8'h81);
    check("after_rst_done_at", dat, 160);
    @(negedge clk);
    for (int r = 0; r < 30; r++) begin
      i = int'($urandom_range(3));
      b = 8'($urandom);
      nz = 1'($urandom_range(1));
      frame(i, b, 1'b0, nz, dec, b9, dat);
      check("rand_decode", int'(dec), int'(b));
      check("rand_bit9", int'(b9), int'(exp_bit(i, b, 9)));
      check("rand_done_at", dat, 16 * nbits(i));
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises parallel bytes onto a UART line, the transmit counterpart to the receive path. Contains its own 1x bit-rate divider: one `tx_cycle`-clock period per bit, no oversampling. Accepts one character per valid/ready handshake. Emits start bit, data LSB first, optional parity and 1 or 2 stop bits. Sits between the host-side logic and the `tx` pad.

## Interface
- `TX_SYS_CLK`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate.
- `DATA_BITS`, 8: character width; legal values are 5 to 8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 or 2.
- `tx_clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in DATA_BITS: character to send; sampled only at the handshake.
- `tx_valid` in 1: host has a character.
- `tx_ready` out 1: block is idle and can accept a character.
- `tx_serial` out 1: UART line; idles high.
- `tx_busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse at frame completion.

## Operation
- Derived constant `tx_cycle = TX_SYS_CLK / BAUD_RATE` (integer division); defaults give 5208.
- Elaboration error if `tx_cycle < 2`, `DATA_BITS` is outside 5..8, or `STOP_BITS` is outside 1..2.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- Transition rules:
  - IDLE→START when `tx_valid && tx_ready`.
  - START→DATA after 1 bit period.
  - DATA→PARITY (if `PARITY_EN`) or DATA→STOP after `DATA_BITS` bit periods.
  - PARITY→STOP after 1 bit period.
  - STOP→IDLE after `STOP_BITS` bit periods.
- On handshake:
  - `tx_data` is captured into a shift register.
  - The parity bit is computed from the captured data: even → XOR of data, odd → XNOR of data.
  - The bit counter and baud counter are cleared.
- Baud counter:
  - Runs only outside IDLE.
  - Counts 0..`tx_cycle-1`.
  - The terminal count produces `bit_tick`, which advances the bit or state and reloads the counter to 0.
- Line levels: START drives 0, DATA drives `shift[0]` then shifts right, PARITY drives the parity bit, STOP drives 1.
- `tx_serial` is registered; no combinational path from inputs.
- `tx_ready = !rst && state==IDLE`.
- `tx_busy = state!=IDLE`.
- `tx_valid` while busy is ignored; no queuing.
- Changes on `tx_data` after the handshake do not affect the frame in flight.
- Reset asserted at any time:
  - Outputs go to reset values asynchronously and the frame is aborted.
  - The line returns high immediately.
- Reset values: `tx_serial`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=0 while `rst` is high and 1 after release; state IDLE; counters 0.

## Timing
- Handshake at edge E: from E+1, `tx_serial`=0 and `tx_busy`=1.
- Each bit lasts exactly `tx_cycle` clocks.
- Frame length is `F = tx_cycle*(1+DATA_BITS+PARITY_EN+STOP_BITS)` clocks.
- At edge E+F:
  - State becomes IDLE.
  - `tx_done`=1 for that single cycle.
  - `tx_ready`=1 and `tx_busy`=0.
  - `tx_serial` stays 1.
- Back-to-back frames:
  - With `tx_valid` held high, the next handshake occurs at edge E+F+1.
  - Minimum inter-frame idle is therefore one clock beyond the final stop bit.
- Baud counter width is `$clog2(tx_cycle)`.
- Bit counter width is 3 bits, which covers `DATA_BITS` up to 8 and `STOP_BITS` up to 2.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding localparams (IDLE/START/DATA/PARITY/STOP).
  - The cycles-per-bit computation function, also usable by the receive side.
- One sub-module, `tx_baud_generator`:
  - Ports: `tx_clk`, `rst`, `baud_clr`, `baud_en`, `bit_tick`.
  - Implements a 1x divider with synchronous clear on handshake.
- FSM, shift register and parity logic live in the top module.

## Test plan
All scenarios use `TX_SYS_CLK`=160_000 and `BAUD_RATE`=10_000, giving `tx_cycle`=16.
- **8N1 basic:** send 0x55 → line reads 0,1,0,1,0,1,0,1,0,1, each level held 16 clocks. `tx_done` pulses 160 clocks after the handshake edge, in the same cycle as `tx_ready` rises.
- **Parity:** send 0xA3 with `PARITY_EN`=1 → data bits 1,1,0,0,0,1,0,1. Parity bit is 0 when `PARITY_ODD`=0 and 1 when `PARITY_ODD`=1. `tx_done` at 176 clocks.
- **Back-to-back:** `tx_valid` held high, 0x00 then 0xFF → the second start bit begins exactly 161 clocks after the first, with one extra high clock between frames. Decoded bytes are 0x00 and 0xFF.
- **Busy-time stimulus:** during 0x3C, pulse `tx_valid` with 0xC3 and toggle `tx_data` → 0x3C is transmitted unaltered. No second frame and no `tx_done` until clock 160.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x0F → `tx_serial`=1 and `tx_busy`=0 without waiting for a clock edge. After release, `tx_ready`=1 and a fresh 0x81 frame transmits correctly.
- **Two stop bits:** `STOP_BITS`=2, send 0xFF → line high for 32 clocks after the last data bit. `tx_done` at 176 clocks.
